gate_op_arbiter: RTL and testbench

- Shares one registered bitwise-gate unit (AND/OR/XOR/NAND) among N_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on every request port and on the single response port.
- Sits between client blocks and the gate datapath. Serialises their operations and tags each result with the requester index.

---
 rtl/gate_op_arbiter.sv | 147 ++++++++++++++
 tb/tb_gate_op_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate unit (AND/OR/XOR/NAND) among N_REQ requesters.
// Latency: request accepted at edge t, result visible right after edge t (1 register stage).
// Backpressure: while the result register is full and rsp_ready is low, all req_ready are held low.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b, req_op  per-requester operands (W bits each) and opcode (2 bits each), packed by index
//   rsp_valid/rsp_ready   result handshake; rsp_data is the gate result, rsp_id the requester index
//   grant_cnt             (only with GATE_ARB_STATS_EN) 16-bit saturating accept counter per requester
//
// Optional macro: GATE_ARB_STATS_EN adds the grant_cnt port and its counters.

module gate_op_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*W-1:0]         req_a,
    input  logic [N_REQ*W-1:0]         req_b,
    input  logic [N_REQ*2-1:0]         req_op,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    output logic [W-1:0]               rsp_data,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    input  logic                       rsp_ready
`ifdef GATE_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]        grant_cnt
`endif
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] ptr_nxt;
    logic [N_REQ-1:0] grant;
    logic           found;
    logic           can_accept;
    logic           accept;
    logic [IDW:0]   cand;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [1:0]     sel_op;
    logic [W-1:0]   result;

    // Scan ptr, ptr+1, ... (mod N_REQ) and take the first valid requester.
    // cand is one bit wider so ptr+k cannot overflow before the wrap.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
        grant[gnt_idx] = found;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                sel_a  = req_a[k*W +: W];
                sel_b  = req_b[k*W +: W];
                sel_op = req_op[k*2 +: 2];
            end
        end
    end

    always_comb begin
        case (sel_op)
            2'b00:   result = sel_a & sel_b;
            2'b01:   result = sel_a | sel_b;
            2'b10:   result = sel_a ^ sel_b;
            default: result = ~(sel_a & sel_b);
        endcase
    end

    // A full register can take a new result in the same edge it is drained.
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign accept     = found && can_accept;
    // can_accept is true while held in reset (state is EMPTY), so gate ready explicitly.
    assign req_ready  = rst ? '0 : (grant & {N_REQ{can_accept}});
    assign rsp_valid  = (state == FULL);
    assign ptr_nxt    = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            rsp_data <= '0;
            rsp_id   <= '0;
            ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rsp_data <= result;
                rsp_id   <= gnt_idx;
                ptr      <= ptr_nxt;
            end
        end
    end

`ifdef GATE_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (accept && (gnt_idx == IDW'(i)) && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_cnt[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Self-checking bench for gate_op_arbiter (N_REQ=4, W=8).
// Directed table of single operations, hand-written multi-cycle sequences,
// and a per-cycle reference model feeding an expected-result queue.

module tb_gate_op_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*2-1:0] req_op;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic           rsp_ready;
`ifdef GATE_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    gate_op_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
`ifdef GATE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gate(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic int model_grant(input int p, input logic [3:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Scoreboard: expected results are pushed when the model sees an accept
    // and popped when the DUT's result is consumed.
    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   m_ptr  = 0;
    bit   m_full = 1'b0;

    always @(negedge clk) begin : mon
        int   g;
        bit   acc;
        exp_t e;
        if (rst) begin
            sb.delete();
            m_ptr  = 0;
            m_full = 1'b0;
            chk("mon_rst_ready", 32'(req_ready), 32'h0);
        end else begin
            chk("mon_rsp_valid", 32'(rsp_valid), 32'(m_full));
            if (m_full && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("mon_sb_underflow", 32'(sb.size()), 32'h1);
                end else begin
                    e = sb.pop_front();
                    chk("mon_rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("mon_rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
            g   = model_grant(m_ptr, req_valid);
            acc = (g >= 0) && (!m_full || rsp_ready);
            chk("mon_req_ready", 32'(req_ready), acc ? (32'h1 << g) : 32'h0);
            if (acc) begin
                e.id   = 2'(g);
                e.data = gate(req_op[g*2 +: 2], req_a[g*W +: W], req_b[g*W +: W]);
                sb.push_back(e);
                m_ptr  = (g + 1) % N;
                m_full = 1'b1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    typedef struct {
        int         req;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[7];

    logic [3:0] spv[5];
    int         spe[5];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1, 2'b00, 8'hF0, 8'h3C, 8'h30};
        tbl[1] = '{1, 2'b01, 8'hF0, 8'h3C, 8'hFC};
        tbl[2] = '{1, 2'b10, 8'hF0, 8'h3C, 8'hCC};
        tbl[3] = '{1, 2'b11, 8'hF0, 8'h3C, 8'hCF};
        tbl[4] = '{3, 2'b11, 8'hFF, 8'hFF, 8'h00};
        tbl[5] = '{0, 2'b10, 8'hAA, 8'h55, 8'hFF};
        tbl[6] = '{2, 2'b00, 8'h00, 8'hFF, 8'h00};

        spv[0] = 4'b1000; spe[0] = 3;
        spv[1] = 4'b0100; spe[1] = 2;
        spv[2] = 4'b1000; spe[2] = 3;
        spv[3] = 4'b0110; spe[3] = 1;
        spv[4] = 4'b0100; spe[4] = 2;

        // Reset state, with every requester asserting valid.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(rsp_valid), 32'h0);
        chk("reset_data",  32'(rsp_data),  32'h0);
        chk("reset_id",    32'(rsp_id),    32'h0);
        chk("reset_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;

        // Single operations from the table.
        foreach (tbl[i]) begin
            req_a = '0;
            req_b = '0;
            req_op = '0;
            req_a[tbl[i].req*W +: W]  = tbl[i].a;
            req_b[tbl[i].req*W +: W]  = tbl[i].b;
            req_op[tbl[i].req*2 +: 2] = tbl[i].op;
            req_valid = 4'(1 << tbl[i].req);
            @(negedge clk);
            chk("tbl_pre_valid", 32'(rsp_valid), 32'h0);
            chk("tbl_ready", 32'(req_ready), 32'h1 << tbl[i].req);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("tbl_valid", 32'(rsp_valid), 32'h1);
            chk("tbl_data",  32'(rsp_data),  32'(tbl[i].exp));
            chk("tbl_id",    32'(rsp_id),    32'(tbl[i].req));
            @(posedge clk); #1;
        end

        // Reset while a result is held.
        rsp_ready = 1'b0;
        req_a     = 32'hF0F0F0F0;
        req_b     = 32'h3C3C3C3C;
        req_op    = 8'b11_10_01_00;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("rstmid_pre_valid", 32'(rsp_valid), 32'h1);
        chk("rstmid_pre_id",    32'(rsp_id),    32'h1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(rsp_valid), 32'h0);
        chk("rstmid_id",    32'(rsp_id),    32'h0);
        chk("rstmid_data",  32'(rsp_data),  32'h0);
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        @(negedge clk);
        chk("rstmid_ready0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("rstmid_first_id", 32'(rsp_id), 32'h0);
        chk("rstmid_ready2", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("rstmid_second_id", 32'(rsp_id), 32'h2);

        // Round-robin with everyone valid.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_a     = 32'h44332211;
        req_b     = 32'h0F0F0F0F;
        req_op    = 8'b11_10_01_00;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rr_id",    32'(rsp_id),    32'(k % 4));
            chk("rr_valid", 32'(rsp_valid), 32'h1);
        end

        // Backpressure: ninth accept (requester 0, 11 & 0F) is held.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id",    32'(rsp_id),    32'h0);
            chk("bp_data",  32'(rsp_data),  32'h01);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_id",   32'(rsp_id),   32'h1);
        chk("bp_next_data", 32'(rsp_data), 32'h2F);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // Sparse requests; pointer sits at 3 here.
        foreach (spv[j]) begin
            req_valid = spv[j];
            @(posedge clk); #1;
            chk("sp_id",    32'(rsp_id),    32'(spe[j]));
            chk("sp_valid", 32'(rsp_valid), 32'h1);
        end
        req_valid = '0;

`ifdef GATE_ARB_STATS_EN
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 4'b0001;
        repeat (70000) @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("stats_cnt0", 32'(grant_cnt[15:0]), 32'hFFFF);
        for (int i = 1; i < N; i++) begin
            chk("stats_cnt_other", 32'(grant_cnt[i*16 +: 16]), 32'h0);
        end
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end_sb_empty", 32'(sb.size()), 32'h0);
        chk("end_valid",    32'(rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
